// File: rtl/ex_mem_stage_buffer.sv
// rtl/ex_mem_stage_buffer.sv - EX->MEM pipeline stage buffer with valid/ready, optional skid entry, flush
//
// Purpose:
//   Holds the ALU-stage results (instruction, immediate, ALU result, zero flag,
//   destination register, MEM/WB control bits) between the ALU stage and the
//   data-cache stage. State updates on the falling clock edge. With SKID_ENABLE=1
//   a second (skid) entry lets in_ready come straight from a register. With
//   SKID_ENABLE=0 a single entry is used and in_ready looks through to out_ready.
//
// Ports:
//   clk              pipeline clock (state updates on falling edge)
//   rst              asynchronous active-high reset
//   flush            discard all held entries and the entry offered this edge
//   in_valid/in_ready           upstream handshake
//   in_instruction, in_imm, in_alu_result, in_alu_zero, in_dest_reg, in_ctrl
//                               entry fields offered by the ALU stage
//   out_valid/out_ready         downstream handshake (head entry)
//   out_instruction, out_imm, out_alu_result, out_alu_zero, out_dest_reg, out_ctrl
//                               head entry fields (out_ctrl forced to 0 while invalid)
//   occupancy        number of valid entries held (0..2)

module ex_mem_stage_buffer #(
    parameter int WORD_WIDTH      = 32,
    parameter int REG_INDEX_WIDTH = 5,
    parameter int CTRL_WIDTH      = 6,
    parameter bit SKID_ENABLE     = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_WIDTH-1:0]      in_instruction,
    input  logic [WORD_WIDTH-1:0]      in_imm,
    input  logic [WORD_WIDTH-1:0]      in_alu_result,
    input  logic                       in_alu_zero,
    input  logic [REG_INDEX_WIDTH-1:0] in_dest_reg,
    input  logic [CTRL_WIDTH-1:0]      in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_WIDTH-1:0]      out_instruction,
    output logic [WORD_WIDTH-1:0]      out_imm,
    output logic [WORD_WIDTH-1:0]      out_alu_result,
    output logic                       out_alu_zero,
    output logic [REG_INDEX_WIDTH-1:0] out_dest_reg,
    output logic [CTRL_WIDTH-1:0]      out_ctrl,
    output logic [1:0]                 occupancy
);

    typedef struct packed {
        logic [WORD_WIDTH-1:0]      instruction;
        logic [WORD_WIDTH-1:0]      imm;
        logic [WORD_WIDTH-1:0]      alu_result;
        logic                       alu_zero;
        logic [REG_INDEX_WIDTH-1:0] dest_reg;
        logic [CTRL_WIDTH-1:0]      ctrl;
    } entry_t;

    // Encoding equals the number of valid entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   ready_q, ready_d;
    entry_t in_entry;
    logic   accept;
    logic   drain;

    always_comb begin
        in_entry             = '0;
        in_entry.instruction = in_instruction;
        in_entry.imm         = in_imm;
        in_entry.alu_result  = in_alu_result;
        in_entry.alu_zero    = in_alu_zero;
        in_entry.dest_reg    = in_dest_reg;
        in_entry.ctrl        = in_ctrl;
    end

    assign out_valid = (state_q != ST_EMPTY);

    // Skid mode: in_ready is a flop (only gated by rst) so out_ready never reaches it.
    // Single-entry mode: a consuming head frees the slot within the same edge.
    always_comb begin
        if (SKID_ENABLE) begin
            in_ready = ready_q & ~rst;
        end else begin
            in_ready = ~rst & (~out_valid | out_ready);
        end
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // A drain on this edge was already seen downstream; everything else goes.
            state_d = ST_EMPTY;
        end else if (SKID_ENABLE) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (drain && accept) begin
                        head_d = in_entry;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = ST_TWO;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so nothing new can arrive.
                    if (drain) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            // In single-entry mode an accept while full implies the head drains too.
            if (accept) begin
                head_d  = in_entry;
                state_d = ST_ONE;
            end else if (drain) begin
                state_d = ST_EMPTY;
            end
        end
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign out_instruction = head_q.instruction;
    assign out_imm         = head_q.imm;
    assign out_alu_result  = head_q.alu_result;
    assign out_alu_zero    = head_q.alu_zero;
    assign out_dest_reg    = head_q.dest_reg;
    // Masked so a stale entry can never request a register write or cache access.
    assign out_ctrl        = head_q.ctrl & {CTRL_WIDTH{out_valid}};
    assign occupancy       = state_q;

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// tb/tb_ex_mem_stage_buffer.sv - self-checking bench for ex_mem_stage_buffer (skid and single-entry)

module tb_ex_mem_stage_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, in_alu_zero;
    logic [31:0] in_instruction, in_imm, in_alu_result;
    logic [4:0]  in_dest_reg;
    logic [5:0]  in_ctrl;

    logic        s_in_ready, s_out_valid, s_out_alu_zero;
    logic [31:0] s_out_instruction, s_out_imm, s_out_alu_result;
    logic [4:0]  s_out_dest_reg;
    logic [5:0]  s_out_ctrl;
    logic [1:0]  s_occupancy;

    logic        n_in_ready, n_out_valid, n_out_alu_zero;
    logic [31:0] n_out_instruction, n_out_imm, n_out_alu_result;
    logic [4:0]  n_out_dest_reg;
    logic [5:0]  n_out_ctrl;
    logic [1:0]  n_occupancy;

    ex_mem_stage_buffer #(.WORD_WIDTH(32), .REG_INDEX_WIDTH(5), .CTRL_WIDTH(6), .SKID_ENABLE(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instruction(in_instruction), .in_imm(in_imm), .in_alu_result(in_alu_result),
        .in_alu_zero(in_alu_zero), .in_dest_reg(in_dest_reg), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instruction(s_out_instruction),
        .out_imm(s_out_imm), .out_alu_result(s_out_alu_result), .out_alu_zero(s_out_alu_zero),
        .out_dest_reg(s_out_dest_reg), .out_ctrl(s_out_ctrl), .occupancy(s_occupancy)
    );

    ex_mem_stage_buffer #(.WORD_WIDTH(32), .REG_INDEX_WIDTH(5), .CTRL_WIDTH(6), .SKID_ENABLE(1'b0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instruction(in_instruction), .in_imm(in_imm), .in_alu_result(in_alu_result),
        .in_alu_zero(in_alu_zero), .in_dest_reg(in_dest_reg), .in_ctrl(in_ctrl),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_instruction(n_out_instruction),
        .out_imm(n_out_imm), .out_alu_result(n_out_alu_result), .out_alu_zero(n_out_alu_zero),
        .out_dest_reg(n_out_dest_reg), .out_ctrl(n_out_ctrl), .occupancy(n_occupancy)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        zero;
        logic [4:0]  dest;
        logic [5:0]  ctrl;
    } ent_t;

    // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (single entry).
    ent_t q_s[$];
    ent_t q_n[$];
    int   checks = 0;
    int   errors = 0;
    int   delivered_s = 0;
    bit   acc_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_side(input string p, input bit skid, input ent_t q[$],
                              input logic irdy, input logic ovld, input logic [1:0] occ,
                              input logic [31:0] oi, input logic [31:0] oimm, input logic [31:0] oalu,
                              input logic oz, input logic [4:0] od, input logic [5:0] oc);
        logic exp_rdy;
        ent_t h;
        if (skid) exp_rdy = !rst && (q.size() < 2);
        else      exp_rdy = !rst && (q.size() == 0 || out_ready);
        chk({p, ".in_ready"}, 32'(irdy), 32'(exp_rdy));
        chk({p, ".out_valid"}, 32'(ovld), 32'(q.size() != 0));
        chk({p, ".occupancy"}, 32'(occ), q.size());
        if (q.size() != 0) begin
            h = q[0];
            chk({p, ".instr"}, oi, h.instr);
            chk({p, ".imm"}, oimm, h.imm);
            chk({p, ".alu"}, oalu, h.alu);
            chk({p, ".zero"}, 32'(oz), 32'(h.zero));
            chk({p, ".dest"}, 32'(od), 32'(h.dest));
            chk({p, ".ctrl"}, 32'(oc), 32'(h.ctrl));
        end else begin
            chk({p, ".ctrl_masked"}, 32'(oc), 32'd0);
        end
    endtask

    task automatic check_all();
        check_side("skid", 1'b1, q_s, s_in_ready, s_out_valid, s_occupancy, s_out_instruction,
                   s_out_imm, s_out_alu_result, s_out_alu_zero, s_out_dest_reg, s_out_ctrl);
        check_side("noskid", 1'b0, q_n, n_in_ready, n_out_valid, n_occupancy, n_out_instruction,
                   n_out_imm, n_out_alu_result, n_out_alu_zero, n_out_dest_reg, n_out_ctrl);
    endtask

    task automatic model_edge();
        ent_t e;
        bit   rs, rn;
        e     = '{in_instruction, in_imm, in_alu_result, in_alu_zero, in_dest_reg, in_ctrl};
        acc_s = 1'b0;
        if (rst) begin
            q_s.delete();
            q_n.delete();
        end else begin
            rs = (q_s.size() < 2);
            rn = (q_n.size() == 0) || out_ready;
            if (q_s.size() != 0 && out_ready) begin
                void'(q_s.pop_front());
                delivered_s++;
            end
            if (q_n.size() != 0 && out_ready) void'(q_n.pop_front());
            if (flush) begin
                q_s.delete();
                q_n.delete();
            end else begin
                if (in_valid && rs) begin
                    q_s.push_back(e);
                    acc_s = 1'b1;
                end
                if (in_valid && rn) q_n.push_back(e);
            end
        end
    endtask

    // Inputs are driven 1 unit after a falling edge; outputs are checked 1 unit later.
    task automatic cycle();
        #1;
        check_all();
        @(negedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [31:0] alu, input logic [5:0] ctrl);
        in_valid       = 1'b1;
        in_alu_result  = alu;
        in_ctrl        = ctrl;
        in_instruction = $urandom;
        in_imm         = $urandom;
        in_dest_reg    = 5'($urandom);
        in_alu_zero    = 1'($urandom);
    endtask

    // Upstream holds the entry until the skid stage takes it.
    task automatic offer(input logic [31:0] alu, input logic [5:0] ctrl);
        set_in(alu, ctrl);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (acc_s) break;
        end
        chk("offer_accepted", 32'(acc_s), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instruction = '0; in_imm = '0; in_alu_result = '0; in_alu_zero = 1'b0;
        in_dest_reg = '0; in_ctrl = '0;
        #1;
        chk("rst.instr", s_out_instruction, 32'd0);
        chk("rst.imm", s_out_imm, 32'd0);
        chk("rst.alu", s_out_alu_result, 32'd0);
        chk("rst.dest", 32'(s_out_dest_reg), 32'd0);
        chk("rst.zero", 32'(s_out_alu_zero), 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // back-to-back flow with out_ready high
        out_ready = 1'b1;
        set_in(32'h10, 6'b000011); cycle();
        set_in(32'h20, 6'b000101); cycle();
        set_in(32'h30, 6'b001001); cycle();
        in_valid = 1'b0;
        cycle(); cycle();

        // backpressure fills skid, third entry waits upstream
        out_ready = 1'b0;
        offer(32'hA, 6'b000010);
        offer(32'hB, 6'b000010);
        chk("bp.occ_two", 32'(s_occupancy), 32'd2);
        set_in(32'hC, 6'b000010);
        cycle(); cycle(); cycle();
        chk("bp.c_not_taken", 32'(acc_s), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (acc_s) break;
        end
        chk("bp.c_taken", 32'(acc_s), 32'd1);
        in_valid = 1'b0;
        repeat (4) cycle();

        // flush while full, with an entry offered on the same edge
        out_ready = 1'b0;
        offer(32'h111, 6'b000110);
        offer(32'h222, 6'b000110);
        chk("flush.occ_before", 32'(s_occupancy), 32'd2);
        set_in(32'hDEADBEEF, 6'b000110);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush.valid", 32'(s_out_valid), 32'd0);
        chk("flush.ctrl", 32'(s_out_ctrl), 32'd0);
        chk("flush.occ", 32'(s_occupancy), 32'd0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // single-entry mode with out_ready toggling under continuous input
        for (int i = 0; i < 20; i++) begin
            set_in($urandom, 6'($urandom));
            out_ready = i[0];
            cycle();
            chk("noskid.occ_le1", 32'(n_occupancy <= 2'd1), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        offer(32'h55, 6'b000011);
        offer(32'h66, 6'b000011);
        set_in(32'h77, 6'b000011);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.s_valid", 32'(s_out_valid), 32'd0);
        chk("midrst.s_ctrl", 32'(s_out_ctrl), 32'd0);
        chk("midrst.s_occ", 32'(s_occupancy), 32'd0);
        chk("midrst.s_ready", 32'(s_in_ready), 32'd0);
        chk("midrst.n_valid", 32'(n_out_valid), 32'd0);
        chk("midrst.n_occ", 32'(n_occupancy), 32'd0);
        q_s.delete();
        q_n.delete();
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();

        // randomized traffic against the reference FIFOs
        delivered_s = 0;
        for (int c = 0; c < 40000 && delivered_s < 10000; c++) begin
            in_valid       = ($urandom_range(0, 9) < 7);
            in_instruction = $urandom;
            in_imm         = $urandom;
            in_alu_result  = $urandom;
            in_alu_zero    = 1'($urandom);
            in_dest_reg    = 5'($urandom);
            in_ctrl        = 6'($urandom);
            out_ready      = ($urandom_range(0, 9) < 7);
            flush          = ($urandom_range(0, 63) == 0);
            cycle();
        end
        flush = 1'b0;
        chk("random.delivered_10k", 32'(delivered_s >= 10000), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
